mem_arbiter: RTL and testbench

Shares one downstream memory port between the instruction fetcher (64-bit reads) and the load/store queue (32-bit reads and writes). It sits between the `cpu` memory ports (`i_mem_*`, `lsq_mem_*`) and the single cache port. A registered three-state FSM serves one transaction at a time. The data side has priority, and a starvation counter guarantees forward progress for fetch.

---
 rtl/rv32i_types.sv | 17 +
 rtl/mem_arbiter.sv | 121 ++++++++++++
 tb/tb_mem_arbiter.sv | 229 ++++++++++++++++++++++
 3 files changed

// File: rtl/rv32i_types.sv
// ============================================================================
// rv32i_types : shared CPU type definitions (memory arbiter state encoding)
// Rev 1.0
// ============================================================================
`default_nettype none

package rv32i_types;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      SERVE_I = 2'd1,
      SERVE_D = 2'd2
   } arb_state_t;

endpackage

`default_nettype wire

// File: rtl/mem_arbiter.sv
// ============================================================================
// mem_arbiter : shares one memory port between fetch (64b) and LSQ (32b)
// Rev 1.0
// ============================================================================
`default_nettype none

module mem_arbiter
   import rv32i_types::*;
#(
   parameter int width        = 32,
   parameter int STARVE_LIMIT = 4
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  i_read,
   input  logic [width-1:0]      i_addr,
   output logic [2*width-1:0]    i_rdata,
   output logic                  i_resp,
   input  logic                  d_read,
   input  logic                  d_write,
   input  logic [width/8-1:0]    d_be,
   input  logic [width-1:0]      d_addr,
   input  logic [width-1:0]      d_wdata,
   output logic [width-1:0]      d_rdata,
   output logic                  d_resp,
   output logic                  mem_read,
   output logic                  mem_write,
   output logic [width-1:0]      mem_addr,
   output logic [width/4-1:0]    mem_be,
   output logic [2*width-1:0]    mem_wdata,
   input  logic [2*width-1:0]    mem_rdata,
   input  logic                  mem_resp
);

   localparam logic [2:0] c_limit = 3'(STARVE_LIMIT);

   arb_state_t             r_state;
   arb_state_t             w_next;
   logic                   r_write;
   logic [width-1:0]       r_addr;
   logic [width/4-1:0]     r_be;
   logic [2*width-1:0]     r_wdata;
   logic [2:0]             r_starve;
   logic                   w_d_req;
   logic                   w_grant_i;
   logic                   w_grant_d;

   assign w_d_req = d_read | d_write;
   assign i_rdata = mem_rdata;
   assign d_rdata = mem_rdata[width-1:0];

   always_comb begin
      w_next    = r_state;
      w_grant_i = 1'b0;
      w_grant_d = 1'b0;
      mem_read  = 1'b0;
      mem_write = 1'b0;
      mem_addr  = '0;
      mem_be    = '0;
      mem_wdata = '0;
      i_resp    = 1'b0;
      d_resp    = 1'b0;
      case (r_state)
         IDLE: begin
            // Data side wins unless fetch has been passed over STARVE_LIMIT times
            if (w_d_req && !(i_read && (r_starve == c_limit))) begin
               w_grant_d = 1'b1;
               w_next    = SERVE_D;
            end else if (i_read) begin
               w_grant_i = 1'b1;
               w_next    = SERVE_I;
            end
         end
         SERVE_I, SERVE_D: begin
            mem_read  = ~r_write;
            mem_write = r_write;
            mem_addr  = r_addr;
            mem_be    = r_be;
            mem_wdata = r_wdata;
            if (r_state == SERVE_I) i_resp = mem_resp;
            else                    d_resp = mem_resp;
            if (mem_resp) w_next = IDLE;
         end
         default: w_next = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state  <= IDLE;
         r_write  <= 1'b0;
         r_addr   <= '0;
         r_be     <= '0;
         r_wdata  <= '0;
         r_starve <= '0;
      end else begin
         r_state <= w_next;
         if (w_grant_i) begin
            r_write <= 1'b0;
            r_addr  <= i_addr;
            r_be    <= '1;
            r_wdata <= '0;
         end else if (w_grant_d) begin
            // Write wins if both d_read and d_write are raised
            r_write <= d_write;
            r_addr  <= {d_addr[width-1:2], 2'b00};
            r_be    <= {{(width/8){1'b0}}, d_be};
            r_wdata <= {{width{1'b0}}, d_wdata};
         end
         if (r_state == IDLE) begin
            if (!i_read || w_grant_i)
               r_starve <= '0;
            else if (w_grant_d && (r_starve != c_limit))
               r_starve <= r_starve + 3'd1;
         end
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_mem_arbiter.sv
// ============================================================================
// tb_mem_arbiter : directed stimulus with a transaction-level reference model
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_mem_arbiter;

   localparam int LIMIT = 4;

   logic        clk = 1'b0;
   logic        rst;
   logic        i_read;
   logic [31:0] i_addr;
   logic [63:0] i_rdata;
   logic        i_resp;
   logic        d_read;
   logic        d_write;
   logic [3:0]  d_be;
   logic [31:0] d_addr;
   logic [31:0] d_wdata;
   logic [31:0] d_rdata;
   logic        d_resp;
   logic        mem_read;
   logic        mem_write;
   logic [31:0] mem_addr;
   logic [7:0]  mem_be;
   logic [63:0] mem_wdata;
   logic [63:0] mem_rdata;
   logic        mem_resp;

   int errors = 0;
   int checks = 0;

   mem_arbiter #(.width(32), .STARVE_LIMIT(LIMIT)) dut (
      .clk(clk), .rst(rst),
      .i_read(i_read), .i_addr(i_addr), .i_rdata(i_rdata), .i_resp(i_resp),
      .d_read(d_read), .d_write(d_write), .d_be(d_be), .d_addr(d_addr),
      .d_wdata(d_wdata), .d_rdata(d_rdata), .d_resp(d_resp),
      .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr),
      .mem_be(mem_be), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
      .mem_resp(mem_resp)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s at %0t: got %h want %h", name, $time, act, exp);
      end
   endtask

   // Reference model: who owns the port, what was captured, how long fetch waited
   int          m_own    = 0;   // 0 none, 1 fetch, 2 data
   int          m_starve = 0;
   bit          m_live   = 1'b0;
   logic        m_wr     = 1'b0;
   logic [31:0] m_addr   = '0;
   logic [7:0]  m_be     = '0;
   logic [63:0] m_wd     = '0;

   always @(posedge clk) begin
      if (rst) begin
         m_own    <= 0;
         m_starve <= 0;
         m_live   <= 1'b1;
      end else if (m_own != 0) begin
         if (mem_resp) m_own <= 0;
      end else if ((d_read || d_write) && !(i_read && m_starve >= LIMIT)) begin
         m_own    <= 2;
         m_wr     <= d_write;
         m_addr   <= d_addr & ~32'h3;
         m_be     <= {4'h0, d_be};
         m_wd     <= {32'h0, d_wdata};
         m_starve <= i_read ? ((m_starve + 1 > LIMIT) ? LIMIT : m_starve + 1) : 0;
      end else if (i_read) begin
         m_own    <= 1;
         m_wr     <= 1'b0;
         m_addr   <= i_addr;
         m_be     <= 8'hFF;
         m_wd     <= 64'h0;
         m_starve <= 0;
      end else begin
         m_starve <= 0;
      end
   end

   string dut_log = "";

   always @(negedge clk) begin
      if (m_live) begin
         chk("mem_read",  {63'h0, mem_read},  {63'h0, (m_own == 1) || (m_own == 2 && !m_wr)});
         chk("mem_write", {63'h0, mem_write}, {63'h0, (m_own == 2 && m_wr)});
         chk("mem_addr",  {32'h0, mem_addr},  (m_own != 0) ? {32'h0, m_addr} : 64'h0);
         chk("mem_be",    {56'h0, mem_be},    (m_own != 0) ? {56'h0, m_be} : 64'h0);
         chk("mem_wdata", mem_wdata,          (m_own != 0) ? m_wd : 64'h0);
         chk("i_resp",    {63'h0, i_resp},    {63'h0, (m_own == 1) && mem_resp});
         chk("d_resp",    {63'h0, d_resp},    {63'h0, (m_own == 2) && mem_resp});
         chk("i_rdata",   i_rdata,            mem_rdata);
         chk("d_rdata",   {32'h0, d_rdata},   {32'h0, mem_rdata[31:0]});
         if (i_resp) dut_log = {dut_log, "I"};
         if (d_resp) dut_log = {dut_log, "D"};
      end
   end

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic chk_log(input string name, input string want);
      checks++;
      if (dut_log != want) begin
         errors++;
         $display("FAIL %s: got %s want %s", name, dut_log, want);
      end
   endtask

   initial begin
      rst = 1'b1; i_read = 1'b0; i_addr = '0; d_read = 1'b0; d_write = 1'b0;
      d_be = '0; d_addr = '0; d_wdata = '0; mem_rdata = '0; mem_resp = 1'b0;
      cyc(); cyc();
      @(negedge clk);
      chk("reset_mem_read",  {63'h0, mem_read},  64'h0);
      chk("reset_mem_write", {63'h0, mem_write}, 64'h0);
      cyc();
      rst = 1'b0;
      cyc();

      // Fetch only, memory answers in the fourth serve cycle
      i_read = 1'b1; i_addr = 32'h60;
      cyc();
      @(negedge clk);
      chk("fetch_addr", {32'h0, mem_addr}, 64'h60);
      chk("fetch_be",   {56'h0, mem_be},   64'hFF);
      cyc(); cyc(); cyc();
      mem_resp = 1'b1; mem_rdata = 64'h1111_2222_3333_4444;
      @(negedge clk);
      chk("fetch_resp",  {63'h0, i_resp}, 64'h1);
      chk("fetch_rdata", i_rdata,         64'h1111_2222_3333_4444);
      cyc();
      mem_resp = 1'b0; i_read = 1'b0;
      @(negedge clk);
      chk("fetch_idle", {63'h0, mem_read}, 64'h0);
      cyc();

      // Store with unaligned address, zero-latency response
      d_write = 1'b1; d_addr = 32'h107; d_be = 4'b0011; d_wdata = 32'hDEADBEEF;
      cyc();
      mem_resp = 1'b1;
      @(negedge clk);
      chk("store_addr",   {32'h0, mem_addr}, 64'h104);
      chk("store_be",     {56'h0, mem_be},   64'h03);
      chk("store_wdata",  mem_wdata,         64'h0000_0000_DEAD_BEEF);
      chk("store_dresp",  {63'h0, d_resp},   64'h1);
      chk("store_iresp",  {63'h0, i_resp},   64'h0);
      cyc();
      d_write = 1'b0; mem_resp = 1'b0;
      cyc();

      // Address changes mid-transaction
      d_read = 1'b1; d_addr = 32'h200;
      cyc();
      d_addr = 32'h300;
      @(negedge clk);
      chk("hold_addr1", {32'h0, mem_addr}, 64'h200);
      cyc();
      mem_resp = 1'b1; mem_rdata = 64'hAAAA_BBBB_CCCC_DDDD;
      @(negedge clk);
      chk("hold_addr2", {32'h0, mem_addr}, 64'h200);
      chk("load_rdata", {32'h0, d_rdata},  64'hCCCC_DDDD);
      cyc();
      d_read = 1'b0; mem_resp = 1'b0;
      cyc();

      // Illegal read+write: write wins
      d_read = 1'b1; d_write = 1'b1; d_addr = 32'h40;
      cyc();
      d_read = 1'b0; d_write = 1'b0; mem_resp = 1'b1;
      @(negedge clk);
      chk("illegal_write", {63'h0, mem_write}, 64'h1);
      chk("illegal_read",  {63'h0, mem_read},  64'h0);
      cyc();

      // Stray response while idle
      @(negedge clk);
      chk("stray_dresp", {63'h0, d_resp}, 64'h0);
      chk("stray_iresp", {63'h0, i_resp}, 64'h0);
      cyc();
      mem_resp = 1'b0;
      cyc();

      // Both sides requesting continuously
      dut_log = "";
      i_read = 1'b1; d_read = 1'b1; mem_resp = 1'b1;
      repeat (20) cyc();
      i_read = 1'b0; d_read = 1'b0; mem_resp = 1'b0;
      chk_log("grant_order", "DDDDIDDDDI");
      cyc(); cyc();

      // Reset during SERVE_D with fetch starved part way
      i_read = 1'b1; d_read = 1'b1; mem_resp = 1'b1;
      repeat (6) cyc();
      d_read = 1'b0; d_write = 1'b1; d_addr = 32'h80; d_wdata = 32'h1; d_be = 4'hF;
      mem_resp = 1'b0;
      cyc();
      rst = 1'b1; d_write = 1'b0;
      @(negedge clk);
      chk("pre_rst_write", {63'h0, mem_write}, 64'h1);
      cyc();
      rst = 1'b0; d_read = 1'b1; mem_resp = 1'b1;
      dut_log = "";
      @(negedge clk);
      chk("rst_write", {63'h0, mem_write}, 64'h0);
      chk("rst_dresp", {63'h0, d_resp},    64'h0);
      repeat (10) cyc();
      i_read = 1'b0; d_read = 1'b0; mem_resp = 1'b0;
      chk_log("post_rst_order", "DDDDI");
      cyc(); cyc();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

`default_nettype wire
